// File: rtl/steuerwerk_pkg.sv
// Shared definitions for the Hans control unit: one-hot state codes,
// error code constants and small state-decoding helpers.
package steuerwerk_pkg;

    typedef enum logic [9:0] {
        S_RUHE       = 10'b00_0000_0001,
        S_FETCH      = 10'b00_0000_0010,
        S_DECODE     = 10'b00_0000_0100,
        S_ALU        = 10'b00_0000_1000,
        S_WB_JUMP    = 10'b00_0001_0000,
        S_WB_STORE   = 10'b00_0010_0000,
        S_WB_LOAD    = 10'b00_0100_0000,
        S_WB_DEFAULT = 10'b00_1000_0000,
        S_HALT       = 10'b01_0000_0000,
        S_FEHLER     = 10'b10_0000_0000
    } zustand_t;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_FETCH = 2'd1;
    localparam logic [1:0] FC_ALU   = 2'd2;
    localparam logic [1:0] FC_MEM   = 2'd3;

    function automatic logic ist_wb(input zustand_t z);
        return (z == S_WB_JUMP) || (z == S_WB_STORE) ||
               (z == S_WB_LOAD) || (z == S_WB_DEFAULT);
    endfunction

endpackage

// File: rtl/steuerwerk_watchdog.sv
// Handshake wait counter: flags a timeout when the handshake is still missing
// in the TIMEOUT_ZYKLEN-th cycle of a watched state. TIMEOUT_ZYKLEN=0 disables it.
module steuerwerk_watchdog #(
    parameter int TIMEOUT_ZYKLEN = 255
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    input  logic handshake,
    output logic timeout
);

    localparam int CW    = (TIMEOUT_ZYKLEN > 0) ? $clog2(TIMEOUT_ZYKLEN + 1) : 1;
    localparam int LIMIT = (TIMEOUT_ZYKLEN > 0) ? (TIMEOUT_ZYKLEN - 1) : 0;
    localparam logic [CW-1:0] LAST  = CW'(LIMIT);
    localparam logic          AKTIV = (TIMEOUT_ZYKLEN > 0);

    logic [CW-1:0] wait_q;
    logic [CW-1:0] wait_d;

    // Next wait count: restart on state entry, saturate at the last cycle.
    always_comb begin
        wait_d = wait_q;
        if (clear) begin
            wait_d = CW'(0);
        end else if (enable && (wait_q != LAST)) begin
            wait_d = wait_q + CW'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    // Wait counter register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wait_q <= CW'(0);
        end else begin
            wait_q <= wait_d;
        end
    end

    assign timeout = AKTIV && enable && !handshake && (wait_q == LAST);

endmodule

// File: rtl/steuerwerk_param.sv
// Multi-cycle control FSM of the Hans processor: fetch/decode/ALU/writeback
// sequencing with handshake watchdogs, debug halt/step and a retire counter.
module steuerwerk_param
    import steuerwerk_pkg::*;
#(
    parameter int DECODE_ZYKLEN  = 2,
    parameter int TIMEOUT_ZYKLEN = 255,
    parameter int ZAEHLER_BREITE = 32
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      BefehlGeladen,
    input  logic                      LoadBefehl,
    input  logic                      StoreBefehl,
    input  logic                      JALBefehl,
    input  logic                      UnbedingterSprungBefehl,
    input  logic                      BedingterSprungBefehl,
    input  logic                      Bedingung,
    input  logic                      AluFertig,
    input  logic                      DatenGeladen,
    input  logic                      DatenGespeichert,
    input  logic                      Halt,
    input  logic                      Schritt,
    input  logic                      FehlerQuittung,
    output logic                      LoadBefehlSignal,
    output logic                      DekodierSignal,
    output logic                      ALUStartSignal,
    output logic                      RegisterSchreibSignal,
    output logic                      LoadDatenSignal,
    output logic                      StoreDatenSignal,
    output logic                      PCSignal,
    output logic                      PCSprungSignal,
    output logic                      Angehalten,
    output logic                      Fehler,
    output logic [1:0]                FehlerCode,
    output logic [ZAEHLER_BREITE-1:0] BefehlsZaehler
);

    localparam int DEC_EFF = (DECODE_ZYKLEN < 1) ? 1 :
                             ((DECODE_ZYKLEN > 8) ? 8 : DECODE_ZYKLEN);
    localparam logic [2:0] DEC_LAST = 3'(DEC_EFF - 1);

    zustand_t                  state_q, state_d;
    logic [2:0]                dec_q, dec_d;
    logic [1:0]                fc_q, fc_d;
    logic [ZAEHLER_BREITE-1:0] cnt_q, cnt_d;

    logic       wd_enable_s;
    logic       wd_handshake_s;
    logic       wd_clear_s;
    logic       wd_timeout_s;
    logic [1:0] fc_kind_s;
    logic       retire_s;

    // Select which handshake the watchdog supervises and the code it reports.
    always_comb begin
        wd_enable_s    = 1'b0;
        wd_handshake_s = 1'b0;
        fc_kind_s      = FC_NONE;
        case (state_q)
            S_FETCH: begin
                wd_enable_s    = 1'b1;
                wd_handshake_s = BefehlGeladen;
                fc_kind_s      = FC_FETCH;
            end
            S_ALU: begin
                wd_enable_s    = 1'b1;
                wd_handshake_s = AluFertig;
                fc_kind_s      = FC_ALU;
            end
            S_WB_STORE: begin
                wd_enable_s    = 1'b1;
                wd_handshake_s = DatenGespeichert;
                fc_kind_s      = FC_MEM;
            end
            S_WB_LOAD: begin
                wd_enable_s    = 1'b1;
                wd_handshake_s = DatenGeladen;
                fc_kind_s      = FC_MEM;
            end
            default: begin
                wd_enable_s    = 1'b0;
                wd_handshake_s = 1'b0;
                fc_kind_s      = FC_NONE;
            end
        endcase
    end

    steuerwerk_watchdog #(
        .TIMEOUT_ZYKLEN(TIMEOUT_ZYKLEN)
    ) u_watchdog (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (wd_clear_s),
        .enable   (wd_enable_s),
        .handshake(wd_handshake_s),
        .timeout  (wd_timeout_s)
    );

    // Next-state logic; a timeout is checked before any handshake or Halt.
    always_comb begin
        state_d  = state_q;
        retire_s = 1'b0;
        case (state_q)
            S_RUHE: state_d = S_FETCH;
            S_FETCH: begin
                if (wd_timeout_s) state_d = S_FEHLER;
                else if (BefehlGeladen) state_d = S_DECODE;
                else state_d = S_FETCH;
            end
            S_DECODE: begin
                if (dec_q == DEC_LAST) state_d = S_ALU;
                else state_d = S_DECODE;
            end
            S_ALU: begin
                if (wd_timeout_s) state_d = S_FEHLER;
                else if (!AluFertig) state_d = S_ALU;
                else if (UnbedingterSprungBefehl || BedingterSprungBefehl) state_d = S_WB_JUMP;
                else if (StoreBefehl) state_d = S_WB_STORE;
                else if (LoadBefehl) state_d = S_WB_LOAD;
                else state_d = S_WB_DEFAULT;
            end
            S_WB_JUMP, S_WB_DEFAULT: begin
                retire_s = 1'b1;
                state_d  = Halt ? S_HALT : S_FETCH;
            end
            S_WB_STORE: begin
                if (wd_timeout_s) begin
                    state_d = S_FEHLER;
                end else if (DatenGespeichert) begin
                    retire_s = 1'b1;
                    state_d  = Halt ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_WB_STORE;
                end
            end
            S_WB_LOAD: begin
                if (wd_timeout_s) state_d = S_FEHLER;
                else if (DatenGeladen) state_d = S_WB_DEFAULT;
                else state_d = S_WB_LOAD;
            end
            S_HALT: begin
                if (Schritt || !Halt) state_d = S_FETCH;
                else state_d = S_HALT;
            end
            S_FEHLER: begin
                if (FehlerQuittung) state_d = S_RUHE;
                else state_d = S_FEHLER;
            end
            default: state_d = S_RUHE;
        endcase
    end

    // Datapath of the FSM: decode cycle count, error code latch, retire counter.
    always_comb begin
        wd_clear_s = (state_d != state_q);
        dec_d      = ((state_q == S_DECODE) && (dec_q != DEC_LAST)) ? (dec_q + 3'd1) : 3'd0;
        fc_d       = (state_d == S_FEHLER) ? ((state_q == S_FEHLER) ? fc_q : fc_kind_s) : FC_NONE;
        cnt_d      = retire_s ? (cnt_q + ZAEHLER_BREITE'(1)) : cnt_q;
    end

    // State and status registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RUHE;
            dec_q   <= 3'd0;
            fc_q    <= FC_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            fc_q    <= fc_d;
            cnt_q   <= cnt_d;
        end
    end

    // JAL writes its link register in the cycle the ALU reports completion.
    assign LoadBefehlSignal      = (state_q == S_FETCH);
    assign DekodierSignal        = (state_q == S_DECODE);
    assign ALUStartSignal        = (state_q == S_ALU);
    assign RegisterSchreibSignal = (state_q == S_WB_DEFAULT) ||
                                   ((state_q == S_ALU) && AluFertig && JALBefehl);
    assign LoadDatenSignal       = (state_q == S_WB_LOAD);
    assign StoreDatenSignal      = (state_q == S_WB_STORE);
    assign PCSignal              = ist_wb(state_q);
    assign PCSprungSignal        = (state_q == S_WB_JUMP) &&
                                   (UnbedingterSprungBefehl || (BedingterSprungBefehl && Bedingung));
    assign Angehalten            = (state_q == S_HALT);
    assign Fehler                = (state_q == S_FEHLER);
    assign FehlerCode            = fc_q;
    assign BefehlsZaehler        = cnt_q;

endmodule

// File: tb/tb_steuerwerk_param.sv
// Table-driven bench for steuerwerk_param (DECODE=2, TIMEOUT=4, 4-bit counter):
// one record per clock cycle with applied inputs and expected outputs.
module tb_steuerwerk_param;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       BefehlGeladen, LoadBefehl, StoreBefehl, JALBefehl;
    logic       UnbedingterSprungBefehl, BedingterSprungBefehl, Bedingung;
    logic       AluFertig, DatenGeladen, DatenGespeichert, Halt, Schritt, FehlerQuittung;
    logic       LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal;
    logic       LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal;
    logic       Angehalten, Fehler;
    logic [1:0] FehlerCode;
    logic [3:0] BefehlsZaehler;

    always #5 Clock = ~Clock;

    steuerwerk_param #(
        .DECODE_ZYKLEN (2),
        .TIMEOUT_ZYKLEN(4),
        .ZAEHLER_BREITE(4)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .BefehlGeladen(BefehlGeladen), .LoadBefehl(LoadBefehl), .StoreBefehl(StoreBefehl),
        .JALBefehl(JALBefehl), .UnbedingterSprungBefehl(UnbedingterSprungBefehl),
        .BedingterSprungBefehl(BedingterSprungBefehl), .Bedingung(Bedingung),
        .AluFertig(AluFertig), .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
        .Halt(Halt), .Schritt(Schritt), .FehlerQuittung(FehlerQuittung),
        .LoadBefehlSignal(LoadBefehlSignal), .DekodierSignal(DekodierSignal),
        .ALUStartSignal(ALUStartSignal), .RegisterSchreibSignal(RegisterSchreibSignal),
        .LoadDatenSignal(LoadDatenSignal), .StoreDatenSignal(StoreDatenSignal),
        .PCSignal(PCSignal), .PCSprungSignal(PCSprungSignal),
        .Angehalten(Angehalten), .Fehler(Fehler),
        .FehlerCode(FehlerCode), .BefehlsZaehler(BefehlsZaehler)
    );

    localparam logic [12:0] I_NO = 13'h0000, I_BG = 13'h1000, I_LD = 13'h0800, I_ST = 13'h0400;
    localparam logic [12:0] I_JL = 13'h0200, I_UJ = 13'h0100, I_BJ = 13'h0080, I_BD = 13'h0040;
    localparam logic [12:0] I_AF = 13'h0020, I_DG = 13'h0010, I_DS = 13'h0008, I_HT = 13'h0004;
    localparam logic [12:0] I_SS = 13'h0002, I_FQ = 13'h0001;

    localparam logic [9:0] O_NO = 10'h000, O_LB = 10'h200, O_DK = 10'h100, O_AS = 10'h080;
    localparam logic [9:0] O_RS = 10'h040, O_LD = 10'h020, O_SD = 10'h010, O_PC = 10'h008;
    localparam logic [9:0] O_PS = 10'h004, O_AH = 10'h002, O_FE = 10'h001;

    typedef struct {
        logic [12:0] stim;
        logic [9:0]  strobes;
        logic [1:0]  code;
        logic [3:0]  count;
    } vec_t;

    vec_t vecs[$];
    int   n_applied    = 0;
    int   n_miscompare = 0;

    task automatic add(input logic [12:0] s, input logic [9:0] o, input logic [1:0] fc,
                       input logic [3:0] c);
        vecs.push_back('{s, o, fc, c});
    endtask

    task automatic apply(input logic [12:0] s);
        {BefehlGeladen, LoadBefehl, StoreBefehl, JALBefehl, UnbedingterSprungBefehl,
         BedingterSprungBefehl, Bedingung, AluFertig, DatenGeladen, DatenGespeichert,
         Halt, Schritt, FehlerQuittung} = s;
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] exp);
        logic [15:0] got;
        got = {LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal,
               LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal,
               Angehalten, Fehler, FehlerCode, BefehlsZaehler};
        n_applied++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s[%0d]: got strobes=%b code=%0d count=%0d, required strobes=%b code=%0d count=%0d",
                     name, idx, got[15:6], got[5:4], got[3:0], exp[15:6], exp[5:4], exp[3:0]);
        end
    endtask

    // Five-cycle instruction with the given inputs; cnt is the value before retire.
    task automatic add_instr(input logic [12:0] s, input logic [9:0] alu_o,
                             input logic [9:0] wb_o, input logic [3:0] c);
        add(s, O_LB, 2'd0, c);
        add(s, O_DK, 2'd0, c);
        add(s, O_DK, 2'd0, c);
        add(s, alu_o, 2'd0, c);
        add(s, wb_o, 2'd0, c);
    endtask

    initial begin
        apply(I_NO);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #1 check("reset_state", 0, 16'h0000);

        // Plain ALU instruction, then branch not taken / taken, then JAL.
        add(I_BG | I_AF, O_NO, 2'd0, 4'd0);
        add_instr(I_BG | I_AF, O_AS, O_RS | O_PC, 4'd0);
        add_instr(I_BG | I_AF | I_BJ, O_AS, O_PC, 4'd1);
        add_instr(I_BG | I_AF | I_BJ | I_BD, O_AS, O_PC | O_PS, 4'd2);
        add_instr(I_BG | I_AF | I_JL, O_AS | O_RS, O_RS | O_PC, 4'd3);
        // Load: ALU waits one cycle, data arrives in the 4th wait cycle.
        add(I_BG | I_LD, O_LB, 2'd0, 4'd4);
        add(I_LD, O_DK, 2'd0, 4'd4);
        add(I_LD, O_DK, 2'd0, 4'd4);
        add(I_LD | I_JL, O_AS, 2'd0, 4'd4);
        add(I_LD | I_AF, O_AS, 2'd0, 4'd4);
        for (int k = 0; k < 3; k++) add(I_LD, O_LD | O_PC, 2'd0, 4'd4);
        add(I_LD | I_DG, O_LD | O_PC, 2'd0, 4'd4);
        add(I_LD, O_RS | O_PC, 2'd0, 4'd4);
        // Store with immediate acknowledge.
        add_instr(I_BG | I_ST | I_AF | I_DS, O_AS, O_SD | O_PC, 4'd5);
        // Load that never completes: memory timeout, acknowledge, restart.
        add(I_BG | I_LD | I_AF, O_LB, 2'd0, 4'd6);
        add(I_LD | I_AF, O_DK, 2'd0, 4'd6);
        add(I_LD | I_AF, O_DK, 2'd0, 4'd6);
        add(I_LD | I_AF, O_AS, 2'd0, 4'd6);
        for (int k = 0; k < 4; k++) add(I_LD, O_LD | O_PC, 2'd0, 4'd6);
        add(I_HT, O_FE, 2'd3, 4'd6);
        add(I_FQ, O_FE, 2'd3, 4'd6);
        add(I_NO, O_NO, 2'd0, 4'd6);
        // Fetch timeout.
        for (int k = 0; k < 4; k++) add(I_NO, O_LB, 2'd0, 4'd6);
        add(I_FQ, O_FE, 2'd1, 4'd6);
        add(I_NO, O_NO, 2'd0, 4'd6);
        // Halt mid-instruction, hold, single step, release.
        add(I_BG | I_AF, O_LB, 2'd0, 4'd6);
        add(I_BG | I_AF | I_HT, O_DK, 2'd0, 4'd6);
        add(I_BG | I_AF | I_HT, O_DK, 2'd0, 4'd6);
        add(I_BG | I_AF | I_HT, O_AS, 2'd0, 4'd6);
        add(I_BG | I_AF | I_HT, O_RS | O_PC, 2'd0, 4'd6);
        add(I_HT, O_AH, 2'd0, 4'd7);
        add(I_HT, O_AH, 2'd0, 4'd7);
        add(I_HT | I_SS | I_BG | I_AF, O_AH, 2'd0, 4'd7);
        add_instr(I_BG | I_AF | I_HT, O_AS, O_RS | O_PC, 4'd7);
        add(I_HT | I_FQ, O_AH, 2'd0, 4'd8);
        add(I_NO, O_AH, 2'd0, 4'd8);
        // Nine more retires: 17 in total wraps the 4-bit counter to 1.
        for (int k = 0; k < 9; k++) add_instr(I_BG | I_AF, O_AS, O_RS | O_PC, 4'(8 + k));
        add(I_BG, O_LB, 2'd0, 4'd1);
        // ALU timeout.
        add(I_NO, O_DK, 2'd0, 4'd1);
        add(I_NO, O_DK, 2'd0, 4'd1);
        for (int k = 0; k < 4; k++) add(I_NO, O_AS, 2'd0, 4'd1);
        add(I_FQ, O_FE, 2'd2, 4'd1);
        add(I_NO, O_NO, 2'd0, 4'd1);

        Reset = 1'b0;
        foreach (vecs[i]) begin
            apply(vecs[i].stim);
            #1 check("vec", i, {vecs[i].strobes, vecs[i].code, vecs[i].count});
            @(negedge Clock);
        end

        // Asynchronous reset while an instruction sits in ALU.
        apply(I_BG);
        for (int k = 0; k < 10 && !ALUStartSignal; k++) begin
            #1;
            if (!ALUStartSignal) @(negedge Clock);
        end
        #1 check("reach_alu", 0, {O_AS, 2'd0, 4'd1});
        Reset = 1'b1;
        #1 check("async_reset", 0, 16'h0000);
        @(negedge Clock);
        Reset = 1'b0;
        #1 check("after_reset_ruhe", 0, 16'h0000);
        @(negedge Clock);
        #1 check("after_reset_fetch", 0, {O_LB, 2'd0, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
